// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between core and data memory.
// Word-aligned req/valid bus, byte lanes, load extension.
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_stall_o,
  output logic        lsu_fault_o,
  output logic        lsu_bus_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] TMAX = LAST[CW-1:0];

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [2:0]    size_q, size_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          fault;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic [31:0]   lane;
  logic [31:0]   ext;

  // Illegal size, misaligned H/W, or unsigned store.
  always_comb begin
    fault = 1'b1;
    case (lsu_size_i)
      3'd0:    fault = 1'b0;
      3'd1:    fault = lsu_addr_i[0];
      3'd2:    fault = |lsu_addr_i[1:0];
      3'd4:    fault = lsu_we_i;
      3'd5:    fault = lsu_we_i | lsu_addr_i[0];
      default: fault = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = lsu_wdata_i;
    case (lsu_size_i[1:0])
      2'd0: begin
        be_n    = 4'b0001 << lsu_addr_i[1:0];
        wdata_n = {4{lsu_wdata_i[7:0]}};
      end
      2'd1: begin
        be_n    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = lsu_wdata_i;
      end
    endcase
  end

  // Lane select and sign/zero extension of the read word.
  always_comb begin
    lane = data_rdata_i >> {addr_q[1:0], 3'b000};
    ext  = data_rdata_i;
    case (size_q)
      3'd0:    ext = {{24{lane[7]}}, lane[7:0]};
      3'd1:    ext = {{16{lane[15]}}, lane[15:0]};
      3'd4:    ext = {24'd0, lane[7:0]};
      3'd5:    ext = {16'd0, lane[15:0]};
      default: ext = data_rdata_i;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    size_d        = size_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    lsu_stall_o   = 1'b0;
    lsu_fault_o   = 1'b0;
    lsu_bus_err_o = 1'b0;
    data_req_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          if (fault) begin
            lsu_fault_o = 1'b1;
          end else begin
            addr_d      = lsu_addr_i;
            we_d        = lsu_we_i;
            size_d      = lsu_size_i;
            be_d        = be_n;
            wdata_d     = wdata_n;
            lsu_stall_o = 1'b1;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        data_req_o  = 1'b1;
        lsu_stall_o = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        lsu_stall_o = 1'b1;
        cnt_d       = cnt_q + CW'(1);
        if (data_rvalid_i) begin
          rdata_d = we_q ? 32'd0 : ext;
          state_d = DONE;
        end else if (TIMEOUT != 0 && cnt_q == TMAX) begin
          lsu_bus_err_o = 1'b1;
          rdata_d       = 32'd0;
          state_d       = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      lsu_stall_o   = 1'b0;
      lsu_fault_o   = 1'b0;
      lsu_bus_err_o = 1'b0;
      data_req_o    = 1'b0;
    end
  end

  // State and latched request registers.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lsu_rdata_o  = rdata_q;
  assign data_addr_o  = {addr_q[31:2], 2'b00};
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: scenario tasks with a load-result scoreboard.
// Memory side is modelled inline by the access driver.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_stall_o;
  logic        lsu_fault_o;
  logic        lsu_bus_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        data_rvalid_i;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  int          n_stall, n_req, n_err, err_off;
  bit          timed_out;
  logic        cap_fault, cap_we;
  logic [31:0] cap_addr, cap_wdata, got_rdata;
  logic [3:0]  cap_be;

  always #5 clk = ~clk;

  riscv_lsu #(.TIMEOUT(16)) dut (
    .clk_i         (clk),
    .reset         (reset),
    .lsu_req_i     (lsu_req_i),
    .lsu_we_i      (lsu_we_i),
    .lsu_size_i    (lsu_size_i),
    .lsu_addr_i    (lsu_addr_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .lsu_rdata_o   (lsu_rdata_o),
    .lsu_stall_o   (lsu_stall_o),
    .lsu_fault_o   (lsu_fault_o),
    .lsu_bus_err_o (lsu_bus_err_o),
    .data_req_o    (data_req_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_rdata_i  (data_rdata_i),
    .data_rvalid_i (data_rvalid_i)
  );

  // Drives one access; delay<0 means memory never answers.
  task automatic run_access(input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rword, input int delay);
    int req_at;
    bit fin;
    n_stall = 0; n_req = 0; n_err = 0; err_off = -1;
    timed_out = 0; req_at = -1; fin = 0;
    cap_fault = 0; cap_we = 0; cap_addr = '0; cap_wdata = '0;
    cap_be = '0; got_rdata = 32'hxxxxxxxx;
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
    lsu_addr_i = addr; lsu_wdata_i = wd;
    data_rdata_i = rword; data_rvalid_i = 1'b0;
    #1;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        data_rvalid_i = (delay >= 0 && req_at >= 0 &&
                         cyc == req_at + 1 + delay);
        #1;
      end
      if (cyc == 0) cap_fault = lsu_fault_o;
      if (lsu_stall_o) n_stall++;
      if (lsu_bus_err_o) begin
        n_err++;
        err_off = cyc - req_at;
      end
      if (data_req_o) begin
        n_req++;
        req_at = cyc;
        cap_addr = data_addr_o; cap_be = data_be_o;
        cap_wdata = data_wdata_o; cap_we = data_we_o;
      end
      if (cyc > 0 && !lsu_stall_o) begin
        fin = 1;
        got_rdata = lsu_rdata_o;
      end
    end
    lsu_req_i = 1'b0;
    data_rvalid_i = 1'b0;
    if (!fin) timed_out = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 0;
    lsu_addr_i = 0; lsu_wdata_i = 0;
    data_rdata_i = 0; data_rvalid_i = 0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({lsu_stall_o, lsu_fault_o, lsu_bus_err_o, data_req_o, data_we_o}
        !== 5'b0)
      $display("FAIL reset_ctl got=%b exp=00000",
               {lsu_stall_o, lsu_fault_o, lsu_bus_err_o, data_req_o, data_we_o});
    else passed++;
    total++;
    if ({lsu_rdata_o, data_addr_o, data_wdata_o, data_be_o} !== 100'd0)
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%b exp=0",
               lsu_rdata_o, data_addr_o, data_wdata_o, data_be_o);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [31:0] e;
    exp_q.push_back(32'hDEADBEEF);
    run_access(1'b0, 3'd2, 32'h08, 32'h0, 32'hDEADBEEF, 0);
    total++;
    if (timed_out) $display("FAIL lw_done got=timeout exp=done");
    else passed++;
    total++;
    if (cap_addr !== 32'h08 || cap_be !== 4'b1111 || cap_we !== 1'b0)
      $display("FAIL lw_bus addr=%h be=%b we=%b exp=00000008/1111/0",
               cap_addr, cap_be, cap_we);
    else passed++;
    total++;
    if (n_stall != 3 || n_req != 1)
      $display("FAIL lw_latency stall=%0d req=%0d exp=3/1", n_stall, n_req);
    else passed++;
    e = exp_q.pop_front();
    total++;
    if (got_rdata !== e) $display("FAIL lw_rdata got=%h exp=%h", got_rdata, e);
    else passed++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  sz[4]  = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ad[4]  = '{32'h03, 32'h03, 32'h02, 32'h02};
    logic [31:0] ex[4]  = '{32'hFFFFFF80, 32'h00000080,
                            32'hFFFF8012, 32'h00008012};
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      run_access(1'b0, sz[i], ad[i], 32'h0, 32'h80123456, i);
      e = exp_q.pop_front();
      total++;
      if (timed_out || got_rdata !== e)
        $display("FAIL load_ext_%0d got=%h exp=%h", i, got_rdata, e);
      else passed++;
    end
  endtask

  task automatic test_store();
    logic [31:0] e;
    exp_q.push_back(32'h0);
    run_access(1'b1, 3'd1, 32'h06, 32'h1234ABCD, 32'h55555555, 1);
    total++;
    if (cap_addr !== 32'h04 || cap_be !== 4'b1100 ||
        cap_wdata !== 32'hABCDABCD || cap_we !== 1'b1)
      $display("FAIL sh_bus addr=%h be=%b wdata=%h we=%b exp=04/1100/abcdabcd/1",
               cap_addr, cap_be, cap_wdata, cap_we);
    else passed++;
    e = exp_q.pop_front();
    total++;
    if (timed_out || got_rdata !== e)
      $display("FAIL sh_rdata got=%h exp=%h", got_rdata, e);
    else passed++;
    run_access(1'b1, 3'd0, 32'h101, 32'h000000AB, 32'h0, 0);
    total++;
    if (cap_addr !== 32'h100 || cap_be !== 4'b0010 ||
        cap_wdata !== 32'hABABABAB)
      $display("FAIL sb_bus addr=%h be=%b wdata=%h exp=100/0010/abababab",
               cap_addr, cap_be, cap_wdata);
    else passed++;
  endtask

  task automatic test_fault();
    logic       wes[3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0] szs[3] = '{3'd2, 3'd4, 3'd3};
    logic [31:0] ads[3] = '{32'h06, 32'h00, 32'h00};
    for (int i = 0; i < 3; i++) begin
      run_access(wes[i], szs[i], ads[i], 32'h0, 32'h0, 0);
      total++;
      if (cap_fault !== 1'b1 || n_stall != 0 || n_req != 0)
        $display("FAIL fault_%0d fault=%b stall=%0d req=%0d exp=1/0/0",
                 i, cap_fault, n_stall, n_req);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    logic [31:0] e;
    exp_q.push_back(32'h0);
    run_access(1'b0, 3'd2, 32'h10, 32'h0, 32'hCAFEF00D, -1);
    total++;
    if (timed_out || n_err != 1 || err_off != 16)
      $display("FAIL timeout_err count=%0d at=%0d exp=1/16", n_err, err_off);
    else passed++;
    total++;
    if (n_stall != 18) $display("FAIL timeout_stall got=%0d exp=18", n_stall);
    else passed++;
    e = exp_q.pop_front();
    total++;
    if (got_rdata !== e) $display("FAIL timeout_rdata got=%h exp=%h", got_rdata, e);
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = 0; lsu_size_i = 3'd2;
    lsu_addr_i = 32'h20; data_rvalid_i = 0;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (lsu_stall_o !== 1'b1) $display("FAIL mid_wait stall=%b exp=1", lsu_stall_o);
    else passed++;
    reset = 1'b1; lsu_req_i = 0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    total++;
    if ({lsu_stall_o, data_req_o, lsu_bus_err_o} !== 3'b0 || lsu_rdata_o !== 0)
      $display("FAIL mid_reset stall=%b req=%b err=%b rdata=%h exp=0",
               lsu_stall_o, data_req_o, lsu_bus_err_o, lsu_rdata_o);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (lsu_stall_o !== 1'b0 || lsu_rdata_o !== 32'h0)
      $display("FAIL post_reset stall=%b rdata=%h exp=0/0", lsu_stall_o, lsu_rdata_o);
    else passed++;
    data_rvalid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, g;
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'hFFFFFF99);
    run_access(1'b0, 3'd2, 32'h40, 32'h0, 32'h11223344, 0);
    got_q.push_back(timed_out ? 32'hxxxxxxxx : got_rdata);
    run_access(1'b0, 3'd0, 32'h42, 32'h0, 32'h0099AABB, 2);
    got_q.push_back(timed_out ? 32'hxxxxxxxx : got_rdata);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) $display("FAIL b2b_%0d got=%h exp=%h", i, g, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_fault();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
